// File: rtl/ara_pkg.sv
// Vector-unit wide definitions shared across the datapath.
//   ELEN   : widest element handled by the lanes
//   elen_t : one element as carried on lane/buffer buses
package ara_pkg;

    localparam int unsigned ELEN = 64;

    typedef logic [ELEN-1:0] elen_t;

endpackage

// File: rtl/matmul_pkg.sv
// Matmul-engine definitions: broadcast-buffer geometry, feeder job descriptor and
// feeder FSM state encoding.
//   MAX_BLEN       : largest broadcast vector the buffer bank can hold
//   MAX_REPS_LIMIT : widest replay count a feeder job descriptor can carry
//   bc_feed_cfg_t  : latched job {blen, reps}
//   bc_feed_state_e: feeder FSM states
package matmul_pkg;

    localparam int unsigned MAX_BLEN       = 16;
    localparam int unsigned MAX_REPS_LIMIT = 256;

    localparam int unsigned BLEN_W = $clog2(MAX_BLEN) + 1;
    localparam int unsigned REPS_W = $clog2(MAX_REPS_LIMIT) + 1;

    typedef struct packed {
        logic [BLEN_W-1:0] blen;
        logic [REPS_W-1:0] reps;
    } bc_feed_cfg_t;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StRelease
    } bc_feed_state_e;

endpackage

// File: rtl/bc_operand_feeder.sv
// Broadcast operand feeder: replays a buffered broadcast vector `reps` times as a
// stream of fp32 scalar operands to the lane-0 FMA, then releases the buffer bank.
//
// Ports
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o       : job handshake (accepted only when idle)
//   cfg_blen_i, cfg_reps_i        : elements per vector (1..MAX_BLEN), passes (1..MaxReps)
//   abort_i                       : kill the running job, release the bank
//   bc_data_i, bc_data_valid_i,
//   bc_data_ready_o               : element stream from the broadcast buffer
//   bc_data_invalidate_o          : one-cycle pulse releasing the buffer bank
//   operand_o, operand_valid_o,
//   operand_ready_i               : fp32 operand stream to the FMA
//   operand_last_o/operand_final_o: last of pass / last of last pass
//   busy_o                        : a job is in flight
module bc_operand_feeder
    import ara_pkg::*;
    import matmul_pkg::*;
#(
    parameter int unsigned NrLanes = 0,
    parameter int unsigned MaxReps = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [BLEN_W-1:0]          cfg_blen_i,
    input  logic [$clog2(MaxReps):0]   cfg_reps_i,
    input  logic                       abort_i,
    input  elen_t                      bc_data_i,
    input  logic                       bc_data_valid_i,
    output logic                       bc_data_ready_o,
    output logic                       bc_data_invalidate_o,
    output logic [31:0]                operand_o,
    output logic                       operand_valid_o,
    input  logic                       operand_ready_i,
    output logic                       operand_last_o,
    output logic                       operand_final_o,
    output logic                       busy_o
);

    // Guarded divisor so the legality check itself never divides by zero.
    localparam int unsigned LanesDiv = (NrLanes == 0) ? 1 : NrLanes;

    if (NrLanes == 0 || (MAX_BLEN % LanesDiv) != 0) begin : g_bad_lanes
        $error("bc_operand_feeder: NrLanes must be >0 and divide MAX_BLEN");
    end

    if (MaxReps < 1 || MaxReps > MAX_REPS_LIMIT) begin : g_bad_reps
        $error("bc_operand_feeder: MaxReps must be in 1..MAX_REPS_LIMIT");
    end

    bc_feed_state_e     state_q;
    bc_feed_cfg_t       cfg_q;
    logic [BLEN_W-1:0]  elem_cnt_q;
    logic [REPS_W-1:0]  rep_cnt_q;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic               out_last_q;
    logic               out_final_q;

    logic up_fire;
    logic down_fire;
    logic elem_last;
    logic elem_final;

    // Upper half of the element is not part of the fp32 operand.
    logic unused_bc_hi;
    assign unused_bc_hi = ^bc_data_i[ELEN-1:32];

    always_comb begin
        // Abort wins over every handshake, so never advertise ready in that cycle.
        bc_data_ready_o = (state_q == StStream) && !abort_i
                          && (!out_valid_q || operand_ready_i);
        up_fire    = bc_data_valid_i && bc_data_ready_o;
        down_fire  = out_valid_q && operand_ready_i;
        elem_last  = (elem_cnt_q == cfg_q.blen - BLEN_W'(1));
        elem_final = elem_last && (rep_cnt_q == cfg_q.reps - REPS_W'(1));
    end

    assign cfg_ready_o          = (state_q == StIdle);
    assign busy_o               = (state_q != StIdle);
    assign bc_data_invalidate_o = (state_q == StRelease);
    assign operand_o            = out_data_q;
    assign operand_valid_o      = out_valid_q;
    assign operand_last_o       = out_last_q;
    assign operand_final_o      = out_final_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cfg_q       <= '0;
            elem_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_final_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid_i) begin
                        cfg_q.blen <= cfg_blen_i;
                        cfg_q.reps <= REPS_W'(cfg_reps_i);
                        elem_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                        state_q    <= StStream;
                    end
                end

                StStream: begin
                    if (abort_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StRelease;
                    end else if (up_fire) begin
                        // A simultaneous downstream accept is covered: the new
                        // element simply overwrites the one just consumed.
                        out_valid_q <= 1'b1;
                        out_data_q  <= bc_data_i[31:0];
                        out_last_q  <= elem_last;
                        out_final_q <= elem_final;
                        if (elem_last) begin
                            elem_cnt_q <= '0;
                            rep_cnt_q  <= rep_cnt_q + REPS_W'(1);
                        end else begin
                            elem_cnt_q <= elem_cnt_q + BLEN_W'(1);
                        end
                        if (elem_final) begin
                            state_q <= StDrain;
                        end
                    end else if (down_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end

                StDrain: begin
                    if (abort_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StRelease;
                    end else if (!out_valid_q || operand_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StRelease;
                    end
                end

                // Already releasing; an abort here must not stretch the pulse.
                StRelease: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bc_operand_feeder.sv
// Bench for bc_operand_feeder: directed jobs plus a random-handshake soak, with a
// scoreboard of expected operands pushed on upstream acceptance.
module tb_bc_operand_feeder;
    import ara_pkg::*;
    import matmul_pkg::*;

    localparam int unsigned NrLanes = 4;
    localparam int unsigned MaxReps = 256;
    localparam int unsigned RepsInW = $clog2(MaxReps) + 1;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [BLEN_W-1:0]  cfg_blen_i;
    logic [RepsInW-1:0] cfg_reps_i;
    logic               abort_i;
    elen_t              bc_data_i;
    logic               bc_data_valid_i;
    logic               bc_data_ready_o;
    logic               bc_data_invalidate_o;
    logic [31:0]        operand_o;
    logic               operand_valid_o;
    logic               operand_ready_i;
    logic               operand_last_o;
    logic               operand_final_o;
    logic               busy_o;

    bc_operand_feeder #(
        .NrLanes (NrLanes),
        .MaxReps (MaxReps)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .cfg_valid_i          (cfg_valid_i),
        .cfg_ready_o          (cfg_ready_o),
        .cfg_blen_i           (cfg_blen_i),
        .cfg_reps_i           (cfg_reps_i),
        .abort_i              (abort_i),
        .bc_data_i            (bc_data_i),
        .bc_data_valid_i      (bc_data_valid_i),
        .bc_data_ready_o      (bc_data_ready_o),
        .bc_data_invalidate_o (bc_data_invalidate_o),
        .operand_o            (operand_o),
        .operand_valid_o      (operand_valid_o),
        .operand_ready_i      (operand_ready_i),
        .operand_last_o       (operand_last_o),
        .operand_final_o      (operand_final_o),
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        fin;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc = 0;

    int fire_cnt, first_fire, last_fire, inv_cnt, inv_cyc, final_cnt, busy_fall, abort_cyc;
    int job_blen = 1;
    int job_reps = 1;
    int up_idx = 0;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last, prev_final;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        logic up_fired;
        @(negedge clk);
        up_fired = 1'b0;
        if (rst_ni && !abort_i) begin
            if (prev_hold) begin
                check("hold_valid", operand_valid_o, 1);
                check("hold_data", operand_o, prev_data);
                check("hold_last", operand_last_o, prev_last);
                check("hold_final", operand_final_o, prev_final);
            end
            if (operand_valid_o && !operand_ready_i) check("stall_up_ready", bc_data_ready_o, 0);
            if (busy_o) check("cfg_ready_busy", cfg_ready_o, 0);
            if (bc_data_valid_i && bc_data_ready_o) begin
                e.data = bc_data_i[31:0];
                e.last = ((up_idx % job_blen) == job_blen - 1);
                e.fin  = (up_idx == job_blen * job_reps - 1);
                exp_q.push_back(e);
                up_idx++;
                up_fired = 1'b1;
            end
            if (operand_valid_o && operand_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("op_data", operand_o, e.data);
                    check("op_last", operand_last_o, e.last);
                    check("op_final", operand_final_o, e.fin);
                end
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                fire_cnt++;
                if (operand_final_o) final_cnt++;
            end
        end
        if (bc_data_invalidate_o) begin
            inv_cnt++;
            inv_cyc = cyc;
        end
        prev_hold  = rst_ni && !abort_i && operand_valid_o && !operand_ready_i;
        prev_data  = operand_o;
        prev_last  = operand_last_o;
        prev_final = operand_final_o;
        @(posedge clk);
        #1;
        cyc++;
        if (up_fired) bc_data_i = {$urandom, $urandom};
    endtask

    task automatic start_job(input int blen, input int reps);
        job_blen = blen;
        job_reps = reps;
        up_idx = 0;
        exp_q.delete();
        fire_cnt = 0; first_fire = -1; last_fire = -1; inv_cnt = 0; inv_cyc = -1;
        final_cnt = 0; busy_fall = -1; abort_cyc = -1;
        cfg_blen_i  = BLEN_W'(blen);
        cfg_reps_i  = RepsInW'(reps);
        cfg_valid_i = 1'b1;
        check("cfg_ready_idle", cfg_ready_o, 1);
        cycle();
        cfg_valid_i = 1'b0;
        check("busy_after_cfg", busy_o, 1);
    endtask

    task automatic run_job(input int rand_mode, input int stall_at, input int abort_at,
                           input int cfg_noise, input int budget);
        int total;
        int stall_left;
        bit stalled_once;
        bit aborted;
        bit done;
        bit abort_now;
        total = job_blen * job_reps;
        stall_left = 0;
        stalled_once = 0;
        aborted = 0;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            bc_data_valid_i = (up_idx < total) && (rand_mode == 0 || $urandom_range(0, 3) != 0);
            operand_ready_i = (rand_mode == 0 || $urandom_range(0, 3) != 0);
            if (stall_at > 0 && up_idx == stall_at && !stalled_once) begin
                stall_left = 3;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                operand_ready_i = 1'b0;
                stall_left--;
            end
            abort_now = (abort_at > 0 && up_idx == abort_at && !aborted);
            abort_i = abort_now;
            if (abort_now) begin
                aborted = 1;
                abort_cyc = cyc;
            end
            cfg_valid_i = (cfg_noise != 0) && (up_idx < total) && !aborted;
            cfg_blen_i  = BLEN_W'(1);
            cycle();
            abort_i = 1'b0;
            if (abort_now) begin
                exp_q.delete();
                check("abort_valid_drop", operand_valid_o, 0);
            end
            if (!busy_o) begin
                done = 1;
                busy_fall = cyc;
            end
        end
        cfg_valid_i = 1'b0;
        bc_data_valid_i = 1'b0;
        check("job_done_in_budget", done, 1);
        if (abort_at == 0) begin
            check("fire_cnt", fire_cnt, total);
            check("final_once", final_cnt, 1);
            check("sb_empty", exp_q.size(), 0);
            check("inv_after_final", inv_cyc, last_fire + 1);
        end else begin
            check("inv_after_abort", inv_cyc, abort_cyc + 1);
        end
        check("inv_one_pulse", inv_cnt, 1);
        check("busy_fall", busy_fall, inv_cyc + 1);
        check("cfg_ready_end", cfg_ready_o, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready_o, 1);
        check({tag, "_bc_ready"}, bc_data_ready_o, 0);
        check({tag, "_valid"}, operand_valid_o, 0);
        check({tag, "_last"}, operand_last_o, 0);
        check({tag, "_final"}, operand_final_o, 0);
        check({tag, "_inv"}, bc_data_invalidate_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_operand"}, operand_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_blen_i = '0;
        cfg_reps_i = '0;
        abort_i = 1'b0;
        bc_data_i = {$urandom, $urandom};
        bc_data_valid_i = 1'b1;
        operand_ready_i = 1'b1;

        // Power-on reset.
        repeat (3) cycle();
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        bc_data_valid_i = 1'b0;
        cycle();
        check_reset_outputs("post_rst");

        // Back-to-back stream, cfg noise ignored while busy.
        start_job(4, 2);
        run_job(0, 0, 0, 1, 100);
        check("t1_fires", fire_cnt, 8);
        check("t1_no_bubble", last_fire - first_fire, 7);

        // Downstream stall mid-stream.
        start_job(4, 1);
        run_job(0, 2, 0, 0, 100);

        // Single element job.
        start_job(1, 1);
        run_job(0, 0, 0, 0, 100);
        check("t3_fires", fire_cnt, 1);

        // Abort after two of eight.
        start_job(8, 1);
        run_job(0, 0, 2, 0, 100);
        check("t4_final_none", final_cnt, 0);

        // Reset mid-stream, then a fresh job.
        start_job(4, 2);
        bc_data_valid_i = 1'b1;
        operand_ready_i = 1'b1;
        repeat (3) cycle();
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
        check_reset_outputs("mid_rst");
        bc_data_valid_i = 1'b0;
        repeat (3) cycle();
        check("mid_rst_no_inv", inv_cnt, 0);
        check("mid_rst_idle", busy_o, 0);
        start_job(3, 2);
        run_job(1, 0, 0, 0, 500);

        // Full-size soak with random handshakes.
        start_job(MAX_BLEN, MaxReps);
        run_job(1, 0, 0, 0, 40000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bc_operand_feeder.md
BC_OPERAND_FEEDER -- requirements
Module: bc_operand_feeder

Interface
REQ-001 Parameter NrLanes, default 0: number of lanes; SHALL be >0 and divide MAX_BLEN.
REQ-002 Parameter MaxReps, default 256: maximum replay passes per broadcast vector.
REQ-003 clk_i  in  1  single clock; all logic SHALL be on rising edge.
REQ-004 rst_ni  in  1  synchronous, active-low reset.
REQ-005 cfg_valid_i / cfg_ready_o  in/out  1  job handshake; transfer when both high.
REQ-006 cfg_blen_i  in  $clog2(MAX_BLEN)+1  elements per broadcast vector, legal 1..MAX_BLEN.
REQ-007 cfg_reps_i  in  $clog2(MaxReps)+1  replay passes, legal 1..MaxReps.
REQ-008 abort_i  in  1  kill current job.
REQ-009 bc_data_i  in  ELEN  broadcast element from buffer; fp32 in [31:0].
REQ-010 bc_data_valid_i / bc_data_ready_o  in/out  1  upstream element handshake.
REQ-011 bc_data_invalidate_o  out  1  one-cycle pulse releasing the current buffer bank.
REQ-012 operand_o  out  32  fp32 scalar operand to lane-0 FMA.
REQ-013 operand_valid_o / operand_ready_i  out/in  1  downstream handshake.
REQ-014 operand_last_o  out  1  element is last of its pass.
REQ-015 operand_final_o  out  1  element is last of last pass.
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, STREAM, DRAIN, RELEASE.
REQ-018 IDLE: cfg_ready_o=1; on cfg handshake latch blen/reps, clear elem_cnt and rep_cnt, go STREAM.
REQ-019 STREAM: bc_data_ready_o = !out_valid_q || operand_ready_i; upstream handshake loads output register (data=bc_data_i[31:0], last, final) in the same edge.
REQ-020 Latency SHALL be one cycle: element accepted at edge N is on operand_o after edge N.
REQ-021 Output register SHALL sustain one element per cycle under continuous valid/ready, with no bubble.
REQ-022 elem_cnt increments per upstream handshake and wraps to 0 at blen-1, incrementing rep_cnt; last=(elem_cnt==blen-1); final=last && (rep_cnt==reps-1).
REQ-023 After the final element is fetched, go DRAIN; bc_data_ready_o SHALL be 0 in DRAIN, RELEASE, IDLE.
REQ-024 DRAIN: when output register empties (final accepted downstream), go RELEASE.
REQ-025 RELEASE: assert bc_data_invalidate_o for exactly one cycle, then go IDLE.
REQ-026 operand_o/last/final SHALL hold stable while operand_valid_o=1 and operand_ready_i=0.
REQ-027 Downstream handshake and upstream handshake in the same cycle SHALL replace the register contents with no loss.
REQ-028 blen=1, reps=1: single element with last=final=1; invalidate exactly one cycle after its downstream acceptance.
REQ-029 abort_i (any non-IDLE state) SHALL clear out_valid_q and go RELEASE next cycle; abort has priority over all handshakes that cycle; abort in IDLE is ignored.
REQ-030 cfg_valid_i outside IDLE SHALL be ignored (cfg_ready_o=0).

Reset
REQ-031 rst_ni=0 at an edge SHALL force IDLE, counters 0, out_valid_q=0, operand_o=0.
REQ-032 During/after reset: cfg_ready_o=1, bc_data_ready_o=0, operand_valid_o=0, last/final=0, bc_data_invalidate_o=0, busy_o=0.
REQ-033 Reset mid-job SHALL NOT emit invalidate; buffer bank recovery is the buffer's own reset.

Structure
REQ-034 MAX_BLEN and typedef bc_feed_cfg_t {blen, reps} SHALL live in matmul_pkg; elen_t from ara_pkg.
REQ-035 No sub-module: output register, counters and FSM inline.
REQ-036 Elaboration error if MAX_BLEN % NrLanes != 0 or MaxReps < 1.

Verification
REQ-037 blen=4, reps=2, always valid/ready -> 8 operands on consecutive cycles, last at 4th and 8th, final only at 8th, one invalidate pulse the cycle after 8th acceptance.
REQ-038 blen=4, reps=1, operand_ready_i low 3 cycles mid-stream -> operand_o stable, bc_data_ready_o=0 while stalled, no element dropped or duplicated.
REQ-039 blen=1, reps=1 -> last=final=1 on the single element; busy_o falls the cycle after the invalidate pulse.
REQ-040 abort_i after 2 of blen=8 elements -> operand_valid_o drops next cycle, one invalidate pulse, IDLE, cfg_ready_o=1.
REQ-041 rst_ni low for one cycle mid-STREAM -> all outputs at reset values, no invalidate, next job runs correctly.
REQ-042 Random valid/ready, blen=MAX_BLEN, reps=MaxReps -> scoreboard: blen*reps operands in order, final exactly once.
